// File: rtl/core_pkg.sv
// Shared core definitions for the MEM stage: LSU op encoding, MEM FSM states
// and small classification helpers used by both the stage and its lane logic.
package core_pkg;

    localparam int LSU_OP_W = 4;

    typedef enum logic [LSU_OP_W-1:0] {
        LSU_NOP = 4'd0,
        LD_B    = 4'd1,
        LD_H    = 4'd2,
        LD_W    = 4'd3,
        LD_BU   = 4'd4,
        LD_HU   = 4'd5,
        ST_B    = 4'd6,
        ST_H    = 4'd7,
        ST_W    = 4'd8
    } lsu_op_t;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_RESP = 2'd2,
        MEM_DONE = 2'd3
    } mem_state_t;

    function automatic logic is_load(input lsu_op_t op);
        case (op)
            LD_B, LD_H, LD_W, LD_BU, LD_HU: is_load = 1'b1;
            default:                        is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input lsu_op_t op);
        case (op)
            ST_B, ST_H, ST_W: is_store = 1'b1;
            default:          is_store = 1'b0;
        endcase
    endfunction

    // Halfword needs addr[0]==0, word needs addr[1:0]==0; bytes never misalign.
    function automatic logic is_misaligned(input lsu_op_t op, input logic [1:0] addr_lo);
        case (op)
            LD_H, LD_HU, ST_H: is_misaligned = addr_lo[0];
            LD_W, ST_W:        is_misaligned = (addr_lo != 2'b00);
            default:           is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-bus interface between the MEM stage (master) and the memory side (slave):
// request/grant for the address phase, rvalid for the response phase.
interface mem_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_wstrb;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    modport master (
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_gnt, d_rvalid, d_rdata
    );

    modport slave (
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_gnt, d_rvalid, d_rdata
    );
endinterface

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: store data replication and byte strobes, and
// load byte/half lane selection with sign or zero extension. 32-bit bus only.
module mem_lsu_align
    import core_pkg::*;
(
    input  lsu_op_t     op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] ld_result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Store side: replicate the datum across all lanes, strobe only the target lanes.
    always_comb begin
        wdata = st_data;
        wstrb = 4'b0000;
        case (op)
            ST_B: begin
                wdata = {4{st_data[7:0]}};
                wstrb = 4'b0001 << addr_lo;
            end
            ST_H: begin
                wdata = {2{st_data[15:0]}};
                wstrb = 4'b0011 << {addr_lo[1], 1'b0};
            end
            ST_W: begin
                wdata = st_data;
                wstrb = 4'b1111;
            end
            default: begin
                wdata = st_data;
                wstrb = 4'b0000;
            end
        endcase
    end

    // Load side: pick the addressed byte/half lane, then extend to 32 bits.
    always_comb begin
        case (addr_lo)
            2'b00:   byte_lane = ld_word[7:0];
            2'b01:   byte_lane = ld_word[15:8];
            2'b10:   byte_lane = ld_word[23:16];
            2'b11:   byte_lane = ld_word[31:24];
            default: byte_lane = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_lane = ld_word[31:16];
        end else begin
            half_lane = ld_word[15:0];
        end
        case (op)
            LD_B:    ld_result = {{24{byte_lane[7]}}, byte_lane};
            LD_BU:   ld_result = {24'h000000, byte_lane};
            LD_H:    ld_result = {{16{half_lane[15]}}, half_lane};
            LD_HU:   ld_result = {16'h0000, half_lane};
            default: ld_result = ld_word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the in-order core. Non-memory ops pass straight through in the
// same cycle; loads/stores run a req/gnt/rvalid bus handshake while holding the
// pipe with stall_req. The EX/MEM inputs stay stable while stalled, so they are
// used directly instead of being re-latched.
// Optional feature: define MEM_ALIGN_CHECK_EN to trap misaligned half/word
// accesses (out_ale) instead of issuing them to the bus.
module mem_stage
    import core_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [31:0]       in_inst,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_ex_result,
    input  logic              in_rw_en,
    input  logic [4:0]        in_rw_addr,
    input  logic [DATA_W-1:0] in_lsu_data,
    input  lsu_op_t           in_lsu_op,
    output logic              stall_req,
    mem_stage_if.master       dbus,
    output logic              out_valid,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_rw_en,
    output logic [4:0]        out_rw_addr,
    output logic [DATA_W-1:0] out_result,
    output logic              out_ale
);

    mem_state_t  state_q;
    mem_state_t  state_d;
    logic        drop_q;
    logic [31:0] rdata_q;

    logic        mem_op;
    logic        misaligned;
    logic        issue;
    logic        kill;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] ld_result;

    mem_lsu_align u_align (
        .op        (in_lsu_op),
        .addr_lo   (in_ex_result[1:0]),
        .st_data   (in_lsu_data),
        .ld_word   (rdata_q),
        .wdata     (st_wdata),
        .wstrb     (st_wstrb),
        .ld_result (ld_result)
    );

    // Classify the EX/MEM op and decide whether a bus access starts this cycle.
    always_comb begin
        mem_op = is_load(in_lsu_op) | is_store(in_lsu_op);
`ifdef MEM_ALIGN_CHECK_EN
        misaligned = mem_op & is_misaligned(in_lsu_op, in_ex_result[1:0]);
`else
        misaligned = 1'b0;
`endif
        issue = in_valid & mem_op & ~flush & ~misaligned;
        // A flushed access still has to absorb its response before going idle.
        kill  = drop_q | flush;
    end

    // State register plus the drop flag and captured load word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MEM_IDLE;
            drop_q  <= 1'b0;
            rdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            if (state_q == MEM_RESP) begin
                if (dbus.d_rvalid) begin
                    drop_q <= 1'b0;
                    if (!kill) begin
                        rdata_q <= dbus.d_rdata;
                    end else begin
                        rdata_q <= rdata_q;
                    end
                end else begin
                    drop_q <= kill;
                end
            end else begin
                drop_q <= 1'b0;
            end
        end
    end

    // Next-state: request until granted, wait for the response, present once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MEM_IDLE: begin
                if (issue) begin
                    state_d = dbus.d_gnt ? MEM_RESP : MEM_REQ;
                end else begin
                    state_d = MEM_IDLE;
                end
            end
            MEM_REQ: begin
                if (flush) begin
                    state_d = MEM_IDLE;
                end else if (dbus.d_gnt) begin
                    state_d = MEM_RESP;
                end else begin
                    state_d = MEM_REQ;
                end
            end
            MEM_RESP: begin
                if (dbus.d_rvalid) begin
                    state_d = kill ? MEM_IDLE : MEM_DONE;
                end else begin
                    state_d = MEM_RESP;
                end
            end
            MEM_DONE: state_d = MEM_IDLE;
            default:  state_d = MEM_IDLE;
        endcase
    end

    // Outputs: bus drive, stall and MEM/WB fields; everything forced low in reset.
    always_comb begin
        dbus.d_req    = 1'b0;
        dbus.d_we     = 1'b0;
        dbus.d_addr   = '0;
        dbus.d_wdata  = '0;
        dbus.d_wstrb  = 4'b0000;
        stall_req     = 1'b0;
        out_valid     = 1'b0;
        out_inst      = 32'h0000_0000;
        out_pc        = '0;
        out_rw_en     = 1'b0;
        out_rw_addr   = 5'd0;
        out_result    = '0;
        out_ale       = 1'b0;
        if (rst) begin
            out_valid = 1'b0;
        end else begin
            dbus.d_we    = is_store(in_lsu_op);
            dbus.d_addr  = {in_ex_result[ADDR_W-1:2], 2'b00};
            dbus.d_wdata = st_wdata;
            dbus.d_wstrb = st_wstrb;
            out_inst     = in_inst;
            out_pc       = in_pc;
            out_rw_en    = in_rw_en;
            out_rw_addr  = in_rw_addr;
            out_result   = in_ex_result;
            case (state_q)
                MEM_IDLE: begin
                    if (in_valid && !flush) begin
                        if (misaligned) begin
                            out_valid = 1'b1;
                            out_ale   = 1'b1;
                            out_rw_en = 1'b0;
                        end else if (mem_op) begin
                            dbus.d_req = 1'b1;
                            stall_req  = 1'b1;
                        end else begin
                            out_valid = 1'b1;
                        end
                    end else begin
                        out_valid = 1'b0;
                    end
                end
                MEM_REQ: begin
                    dbus.d_req = ~flush;
                    stall_req  = ~flush;
                end
                MEM_RESP: begin
                    stall_req = 1'b1;
                end
                MEM_DONE: begin
                    out_valid = ~flush;
                    if (is_load(in_lsu_op)) begin
                        out_result = ld_result;
                    end else begin
                        out_result = in_ex_result;
                    end
                end
                default: begin
                    out_valid = 1'b0;
                end
            endcase
        end
    end

endmodule
